// File: rtl/pipeline_stage1.sv
`timescale 1ns/1ps
// pipeline_stage1 -- instruction fetch stage feeding the stage-2 control ROM.
// Captures opcode bytes from the memory bus and inserts NOP bubbles on stage-2
// bus claims. Handles break/halt and drives the PC increment strobe.
// Optional feature macro: PIPELINE_STAGE1_SINGLE_STEP_EN (HALT -> STEP single stepping).
module pipeline_stage1 #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter logic [7:0]  NOP          = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  mem_data,
  input  logic        bus_request,
  input  logic        break_in,
  input  logic        pcra_flip_in,
  input  logic        step,
  output logic [7:0]  instruction,
  output logic        flag_reset,
  output logic        flag_pcraflip,
  output logic        pc_inc,
  output logic        halted,
  output logic [15:0] fetch_count
);

`ifdef PIPELINE_STAGE1_SINGLE_STEP_EN
  typedef enum logic [1:0] {RSTSEQ, FETCH, HALT, STEP} state_e;
`else
  typedef enum logic [1:0] {RSTSEQ, FETCH, HALT} state_e;
`endif

  // Last value of the reset-sequence counter before moving to FETCH.
  localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic [7:0]  instr_q, instr_d;
  logic        flag_reset_q, flag_reset_d;
  logic        pcra_q, pcra_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

`ifdef PIPELINE_STAGE1_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  // Previous value of step, so a held level yields only one STEP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  // Without single stepping the step input has no function.
  logic unused_step;
  assign unused_step = step;
`endif

  // State and output registers; reset forces the NOP/reset-sequence values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RSTSEQ;
      rst_cnt_q    <= 4'd0;
      instr_q      <= NOP;
      flag_reset_q <= 1'b1;
      pcra_q       <= 1'b0;
      halted_q     <= 1'b0;
      fetch_cnt_q  <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      instr_q      <= instr_d;
      flag_reset_q <= flag_reset_d;
      pcra_q       <= pcra_d;
      halted_q     <= halted_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Next-state logic and the combinational pc_inc strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    instr_d      = instr_q;
    flag_reset_d = flag_reset_q;
    pcra_d       = pcra_q;
    halted_d     = halted_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_inc       = 1'b1;

    // Bank select toggles in every state except the reset sequence, stalls included.
    if ((state_q != RSTSEQ) && pcra_flip_in) pcra_d = ~pcra_q;

    case (state_q)
      RSTSEQ: begin
        instr_d   = NOP;
        rst_cnt_d = rst_cnt_q + 4'd1;
        if (rst_cnt_q == RST_LAST) begin
          state_d      = FETCH;
          flag_reset_d = 1'b0;
        end
      end

      HALT: begin
        instr_d = NOP;
`ifdef PIPELINE_STAGE1_SINGLE_STEP_EN
        if (step_rise) begin
          state_d  = STEP;
          halted_d = 1'b0;
        end
`endif
      end

      // FETCH, and STEP when compiled in: break beats bus_request beats capture.
      default: begin
        if (break_in) begin
          instr_d  = NOP;
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          if (bus_request) begin
            instr_d = NOP;
          end else begin
            instr_d     = mem_data;
            pc_inc      = 1'b0;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
          end
`ifdef PIPELINE_STAGE1_SINGLE_STEP_EN
          if (state_q == STEP) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  assign instruction   = instr_q;
  assign flag_reset    = flag_reset_q;
  assign flag_pcraflip = pcra_q;
  assign halted        = halted_q;
  assign fetch_count   = fetch_cnt_q;

endmodule

// File: tb/tb_pipeline_stage1.sv
`timescale 1ns/1ps
// Testbench for pipeline_stage1: scenario tasks with a scoreboard of expected
// instruction bytes, plus inline checks of the flag/count outputs.
module tb_pipeline_stage1;

`ifdef PIPELINE_STAGE1_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  mem_data;
  logic        bus_request;
  logic        break_in;
  logic        pcra_flip_in;
  logic        step;
  logic [7:0]  instruction;
  logic        flag_reset;
  logic        flag_pcraflip;
  logic        pc_inc;
  logic        halted;
  logic [15:0] fetch_count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  exp_q[$];

  pipeline_stage1 #(.RESET_CYCLES(4), .NOP(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_data     (mem_data),
    .bus_request  (bus_request),
    .break_in     (break_in),
    .pcra_flip_in (pcra_flip_in),
    .step         (step),
    .instruction  (instruction),
    .flag_reset   (flag_reset),
    .flag_pcraflip(flag_pcraflip),
    .pc_inc       (pc_inc),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // Drive all data inputs, then let combinational outputs settle.
  task automatic set_in(input logic [7:0] md, input logic br, input logic brk,
                        input logic pf, input logic st);
    mem_data     = md;
    bus_request  = br;
    break_in     = brk;
    pcra_flip_in = pf;
    step         = st;
    #1;
  endtask

  // Queue the expected capture, clock once, then pop and compare it.
  task automatic tick(input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (instruction !== e) begin
      fails++;
      $display("FAIL %s: instruction=%h expected=%h", tag, instruction, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8'h00, "reset_hold");
    tests++;
    if (flag_reset !== 1'b1 || flag_pcraflip !== 1'b0 || halted !== 1'b0 ||
        fetch_count !== 16'd0 || pc_inc !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: flag_reset=%b pcraflip=%b halted=%b count=%h pc_inc=%b expected 1 0 0 0000 1",
               flag_reset, flag_pcraflip, halted, fetch_count, pc_inc);
    end
    reset = 1'b0;
    // Four reset-sequence edges; a flip pulse and a bus request are ignored here.
    for (int i = 1; i <= 4; i++) begin
      set_in(8'h3C, (i == 3), 1'b0, (i == 2), 1'b0);
      tests++;
      if (flag_reset !== 1'b1 || pc_inc !== 1'b1) begin
        fails++;
        $display("FAIL rstseq_edge%0d: flag_reset=%b pc_inc=%b expected 1 1", i, flag_reset, pc_inc);
      end
      tick(8'h00, "rstseq_nop");
    end
    tests++;
    if (flag_reset !== 1'b0 || flag_pcraflip !== 1'b0) begin
      fails++;
      $display("FAIL rstseq_exit: flag_reset=%b pcraflip=%b expected 0 0", flag_reset, flag_pcraflip);
    end
    set_in(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (pc_inc !== 1'b0) begin
      fails++;
      $display("FAIL first_fetch_pc_inc: pc_inc=%b expected 0", pc_inc);
    end
    tick(8'h3C, "first_fetch");
    exp_cnt = 16'd1;
    tests++;
    if (fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL first_fetch_count: fetch_count=%h expected %h", fetch_count, exp_cnt);
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 2; i++) begin
      set_in(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
      tests++;
      if (pc_inc !== 1'b1) begin
        fails++;
        $display("FAIL bubble_pc_inc: pc_inc=%b expected 1", pc_inc);
      end
      tick(8'h00, "bubble_nop");
      tests++;
      if (fetch_count !== exp_cnt) begin
        fails++;
        $display("FAIL bubble_count: fetch_count=%h expected %h", fetch_count, exp_cnt);
      end
    end
    set_in(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8'h12, "bubble_release");
    exp_cnt++;
    tests++;
    if (fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL bubble_release_count: fetch_count=%h expected %h", fetch_count, exp_cnt);
    end
  endtask

  task automatic test_pcra_flip();
    logic [7:0] md[4]  = '{8'h21, 8'h2F, 8'h22, 8'h23};
    logic       br[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       pf[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       exf[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_in(md[i], br[i], 1'b0, pf[i], 1'b0);
      tick(br[i] ? 8'h00 : md[i], "pcra_capture");
      if (!br[i]) exp_cnt++;
      tests++;
      if (flag_pcraflip !== exf[i]) begin
        fails++;
        $display("FAIL pcra_step%0d: flag_pcraflip=%b expected %b", i, flag_pcraflip, exf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] md[6] = '{8'hDE, 8'h00, 8'hAD, 8'hFF, 8'h5A, 8'h01};
    for (int i = 0; i < 6; i++) begin
      set_in(md[i], 1'b0, 1'b0, 1'b0, 1'b0);
      tick(md[i], "b2b_capture");
      exp_cnt++;
    end
    tests++;
    if (fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL b2b_count: fetch_count=%h expected %h", fetch_count, exp_cnt);
    end
  endtask

  task automatic test_break_priority();
    set_in(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (pc_inc !== 1'b1) begin
      fails++;
      $display("FAIL break_pc_inc: pc_inc=%b expected 1", pc_inc);
    end
    tick(8'h00, "break_nop");
    tests++;
    if (halted !== 1'b1 || fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL break_entry: halted=%b count=%h expected 1 %h", halted, fetch_count, exp_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      set_in(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      tests++;
      if (pc_inc !== 1'b1) begin
        fails++;
        $display("FAIL halt_pc_inc%0d: pc_inc=%b expected 1", i, pc_inc);
      end
      tick(8'h00, "halt_nop");
    end
    tests++;
    if (halted !== 1'b1 || fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL halt_hold: halted=%b count=%h expected 1 %h", halted, fetch_count, exp_cnt);
    end
  endtask

  task automatic test_step();
    for (int i = 1; i <= 5; i++) begin
      set_in(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (pc_inc !== ((STEP_EN && i == 2) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL step_pc_inc%0d: pc_inc=%b expected %b", i, pc_inc, !(STEP_EN && i == 2));
      end
      tick((STEP_EN && i == 2) ? 8'hA5 : 8'h00, "step_capture");
      tests++;
      if (halted !== ((STEP_EN && i == 1) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL step_halted%0d: halted=%b expected %b", i, halted, !(STEP_EN && i == 1));
      end
    end
    if (STEP_EN) exp_cnt++;
    set_in(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8'h00, "step_release");
    tests++;
    if (fetch_count !== exp_cnt || halted !== 1'b1) begin
      fails++;
      $display("FAIL step_count: fetch_count=%h halted=%b expected %h 1", fetch_count, halted, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    set_in(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8'h00, "areset_pre");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(8'h00, "areset_pre_seq");
    set_in(8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(8'h41, "areset_fetch");
    set_in(8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    // Mid-cycle: reset must take effect with no clock edge.
    reset = 1'b1;
    #1;
    tests++;
    if (instruction !== 8'h00 || flag_reset !== 1'b1 || flag_pcraflip !== 1'b0 ||
        halted !== 1'b0 || fetch_count !== 16'd0 || pc_inc !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: instr=%h flag_reset=%b pcra=%b halted=%b count=%h pc_inc=%b expected 00 1 0 0 0000 1",
               instruction, flag_reset, flag_pcraflip, halted, fetch_count, pc_inc);
    end
    tick(8'h00, "areset_held");
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(8'h00, "areset_seq");
      tests++;
      if (flag_reset !== (i < 4)) begin
        fails++;
        $display("FAIL areset_seq%0d: flag_reset=%b expected %b", i, flag_reset, (i < 4));
      end
    end
  endtask

  task automatic test_wrap();
    set_in(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    tests++;
    if (fetch_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload: fetch_count=%h expected ffff", fetch_count);
    end
    tick(8'h77, "wrap_capture");
    tests++;
    if (fetch_count !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_zero: fetch_count=%h expected 0000", fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_bubble();
    test_pcra_flip();
    test_back_to_back();
    test_break_priority();
    test_step();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
